// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared opcodes and state encoding for CPU run control
//
// Purpose: monitor command opcodes and the run-control state encoding. The
// monitor command decoder also imports this package, so the opcode values
// are fixed here.
// Contents:
//   OP_RUN / OP_STEP / OP_HALT / OP_BRK  2-bit command opcodes
//   run_state_e                          run-control FSM states
package cpu_run_ctrl_pkg;

  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_HALT = 2'd2;
  localparam logic [1:0] OP_BRK  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_CALIB = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP       = 3'd3,
    ST_HALTING    = 3'd4
  } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run-control initiator driving the CPU start/quit interface
//
// Purpose: accepts decoded monitor commands (run, N-step, halt, breakpoint),
// waits for DRAM calibration, issues one-cycle cpu_start / quit_cmd pulses,
// counts retired instructions in step mode, matches the retired PC against a
// breakpoint, and waits for the pipeline stall before returning to idle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   init_calib_complete   DRAM calibration done
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_data command payload
//   stall                 pipeline stall from the CPU status block
//   inst_retire/pc_retire retirement strobe and PC
//   cpu_start, quit_cmd   registered single-cycle pulses to the CPU status block
//   running               state is RUN or STEP
//   break_hit, halt_tmo   sticky cause flags for the last halt
//   done                  one-cycle pulse on return to idle
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int STEP_W   = 16,
  parameter int HALT_TMO = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_calib_complete,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  input  logic        stall,
  input  logic        inst_retire,
  input  logic [31:0] pc_retire,
  output logic        cpu_start,
  output logic        quit_cmd,
  output logic        running,
  output logic        break_hit,
  output logic        halt_tmo,
  output logic        done
);

  localparam int TMO_W = (HALT_TMO < 1) ? 1 : $clog2(HALT_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TMO);

  run_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0]       brk_pc_q, brk_pc_d;
  logic              brk_en_q, brk_en_d;
  logic              pend_step_q, pend_step_d;
  logic              cpu_start_q, cpu_start_d;
  logic              quit_cmd_q, quit_cmd_d;
  logic              break_hit_q, break_hit_d;
  logic              halt_tmo_q, halt_tmo_d;
  logic              done_q, done_d;

  logic              accept;
  logic [STEP_W-1:0] step_count;
  logic              brk_match;
  logic              step_last;
  logic              halt_req;
  logic              go;
  logic              go_step;

  assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_STEP);
  assign running    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign accept     = cmd_valid & cmd_ready;
  assign step_count = cmd_data[STEP_W-1:0];

  // Compares use the breakpoint registers as they were before this cycle's
  // BRK command, so a BRK arriving with a retire does not match that retire.
  assign brk_match  = inst_retire & brk_en_q & (pc_retire == brk_pc_q);
  assign step_last  = inst_retire & (step_cnt_q == STEP_W'(1));

  assign cpu_start  = cpu_start_q;
  assign quit_cmd   = quit_cmd_q;
  assign break_hit  = break_hit_q;
  assign halt_tmo   = halt_tmo_q;
  assign done       = done_q;

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    brk_pc_d    = brk_pc_q;
    brk_en_d    = brk_en_q;
    pend_step_d = pend_step_q;
    cpu_start_d = 1'b0;
    quit_cmd_d  = 1'b0;
    break_hit_d = break_hit_q;
    halt_tmo_d  = halt_tmo_q;
    done_d      = 1'b0;
    halt_req    = 1'b0;
    go          = 1'b0;
    go_step     = 1'b0;

    // BRK is serviced in every ready state and never changes state.
    if (accept && (cmd_op == OP_BRK)) begin
      brk_pc_d = {cmd_data[31:2], 2'b00};
      brk_en_d = cmd_data[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              go          = 1'b1;
              break_hit_d = 1'b0;
              halt_tmo_d  = 1'b0;
            end
            OP_STEP: begin
              if (step_count == '0) begin
                done_d = 1'b1;
              end else begin
                go          = 1'b1;
                go_step     = 1'b1;
                step_cnt_d  = step_count;
                break_hit_d = 1'b0;
                halt_tmo_d  = 1'b0;
              end
            end
            OP_HALT: done_d = 1'b1;
            default: ;
          endcase
        end
        // The RUN/STEP choice is remembered so WAIT_CALIB knows where to go.
        if (go) begin
          pend_step_d = go_step;
          if (init_calib_complete) begin
            state_d     = go_step ? ST_STEP : ST_RUN;
            cpu_start_d = 1'b1;
          end else begin
            state_d = ST_WAIT_CALIB;
          end
        end
      end

      ST_WAIT_CALIB: begin
        if (init_calib_complete) begin
          state_d     = pend_step_q ? ST_STEP : ST_RUN;
          cpu_start_d = 1'b1;
        end
      end

      ST_RUN, ST_STEP: begin
        if (!init_calib_complete) begin
          // The CPU stops itself on calibration loss; no quit is sent.
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          if ((state_q == ST_STEP) && inst_retire && (step_cnt_q != '0)) begin
            step_cnt_d = step_cnt_q - STEP_W'(1);
          end
          halt_req = (accept && (cmd_op == OP_HALT)) || brk_match ||
                     ((state_q == ST_STEP) && step_last);
          if (halt_req) begin
            quit_cmd_d = 1'b1;
            state_d    = ST_HALTING;
            tmo_cnt_d  = '0;
            if (brk_match) begin
              break_hit_d = 1'b1;
            end
          end
        end
      end

      ST_HALTING: begin
        if (!init_calib_complete || stall) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          halt_tmo_d = 1'b1;
          state_d    = ST_IDLE;
          done_d     = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      brk_pc_q    <= '0;
      brk_en_q    <= 1'b0;
      pend_step_q <= 1'b0;
      cpu_start_q <= 1'b0;
      quit_cmd_q  <= 1'b0;
      break_hit_q <= 1'b0;
      halt_tmo_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      brk_pc_q    <= brk_pc_d;
      brk_en_q    <= brk_en_d;
      pend_step_q <= pend_step_d;
      cpu_start_q <= cpu_start_d;
      quit_cmd_q  <= quit_cmd_d;
      break_hit_q <= break_hit_d;
      halt_tmo_q  <= halt_tmo_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_calib_complete = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        stall = 1'b0;
  logic        inst_retire = 1'b0;
  logic [31:0] pc_retire = 32'd0;
  logic        cmd_ready, cpu_start, quit_cmd, running, break_hit, halt_tmo, done;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_data            (cmd_data),
    .stall               (stall),
    .inst_retire         (inst_retire),
    .pc_retire           (pc_retire),
    .cpu_start           (cpu_start),
    .quit_cmd            (quit_cmd),
    .running             (running),
    .break_hit           (break_hit),
    .halt_tmo            (halt_tmo),
    .done                (done)
  );

  localparam int P_IDLE = 0, P_WAIT = 1, P_RUN = 2, P_STEP = 3, P_HALT = 4;
  localparam int TMO = 15;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int base = 0;

  int last_start = -1, last_quit = -1, last_done = -1;
  int n_start = 0, n_quit = 0, n_done = 0;

  // Reference model: where the controller is, how many steps remain,
  // how long it has waited for stall, and the registered outputs.
  int          m_phase = P_IDLE;
  bit          m_pend = 1'b0;
  int          m_steps = 0;
  int          m_wait = 0;
  logic [31:0] m_brk_pc = 32'd0;
  bit          m_brk_on = 1'b0;
  bit          m_start = 1'b0, m_quit = 1'b0, m_done = 1'b0, m_bh = 1'b0, m_ht = 1'b0;

  task automatic model_reset();
    m_phase = P_IDLE; m_pend = 1'b0; m_steps = 0; m_wait = 0;
    m_brk_pc = 32'd0; m_brk_on = 1'b0;
    m_start = 1'b0; m_quit = 1'b0; m_done = 1'b0; m_bh = 1'b0; m_ht = 1'b0;
  endtask

  task automatic model_tick();
    bit rdy, acc, hit_b, hit_s, go, go_step;
    int n;
    m_start = 1'b0; m_quit = 1'b0; m_done = 1'b0;
    go = 1'b0; go_step = 1'b0;
    rdy   = (m_phase == P_IDLE) || (m_phase == P_RUN) || (m_phase == P_STEP);
    acc   = cmd_valid && rdy;
    hit_b = inst_retire && m_brk_on && (pc_retire == m_brk_pc);
    hit_s = (m_phase == P_STEP) && inst_retire && (m_steps == 1);
    case (m_phase)
      P_IDLE: if (acc) begin
        if (cmd_op == 2'd0) begin
          go = 1'b1; m_bh = 1'b0; m_ht = 1'b0;
        end else if (cmd_op == 2'd1) begin
          n = int'(cmd_data & 32'h0000_FFFF);
          if (n == 0) m_done = 1'b1;
          else begin go = 1'b1; go_step = 1'b1; m_steps = n; m_bh = 1'b0; m_ht = 1'b0; end
        end else if (cmd_op == 2'd2) begin
          m_done = 1'b1;
        end
        if (go) begin
          m_pend = go_step;
          if (init_calib_complete) begin
            m_phase = go_step ? P_STEP : P_RUN;
            m_start = 1'b1;
          end else m_phase = P_WAIT;
        end
      end
      P_WAIT: if (init_calib_complete) begin
        m_phase = m_pend ? P_STEP : P_RUN;
        m_start = 1'b1;
      end
      P_RUN, P_STEP: begin
        if (!init_calib_complete) begin
          m_phase = P_IDLE; m_done = 1'b1;
        end else begin
          if ((m_phase == P_STEP) && inst_retire && (m_steps > 0)) m_steps = m_steps - 1;
          if ((acc && cmd_op == 2'd2) || hit_b || hit_s) begin
            m_quit = 1'b1; m_phase = P_HALT; m_wait = 0;
            if (hit_b) m_bh = 1'b1;
          end
        end
      end
      P_HALT: begin
        if (!init_calib_complete || stall) begin
          m_phase = P_IDLE; m_done = 1'b1;
        end else if (m_wait == TMO) begin
          m_ht = 1'b1; m_phase = P_IDLE; m_done = 1'b1;
        end else m_wait = m_wait + 1;
      end
      default: m_phase = P_IDLE;
    endcase
    if (acc && cmd_op == 2'd3) begin
      m_brk_pc = cmd_data & 32'hFFFF_FFFC;
      m_brk_on = cmd_data[0];
    end
  endtask

  task automatic compare_cycle();
    logic [6:0] act, exp;
    bit rdy, run;
    rdy = (m_phase == P_IDLE) || (m_phase == P_RUN) || (m_phase == P_STEP);
    run = (m_phase == P_RUN) || (m_phase == P_STEP);
    act = {cmd_ready, cpu_start, quit_cmd, running, break_hit, halt_tmo, done};
    exp = {rdy, m_start, m_quit, run, m_bh, m_ht, m_done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp cyc=%0d rdy/start/quit/run/bh/ht/done actual=%b required=%b",
               cyc_n, act, exp);
    end
    if (cpu_start === 1'b1) begin n_start++; last_start = cyc_n; end
    if (quit_cmd === 1'b1)  begin n_quit++;  last_quit = cyc_n;  end
    if (done === 1'b1)      begin n_done++;  last_done = cyc_n;  end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_tick();
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) compare_cycle();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] d);
    base = cyc_n;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    cyc(1);
    cmd_valid = 1'b0; cmd_data = 32'd0;
  endtask

  task automatic retire(input logic [31:0] pc);
    inst_retire = 1'b1; pc_retire = pc;
    cyc(1);
    inst_retire = 1'b0;
  endtask

  task automatic stall_out();
    stall = 1'b1;
    cyc(2);
    stall = 1'b0;
    cyc(1);
  endtask

  initial begin
    int s, q, c, h, r;
    cyc(2);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pulses", {29'd0, cpu_start, quit_cmd, done}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Calibrated RUN, then HALT, then stall completes the halt.
    s = n_start;
    send(2'd0, 32'd0);
    c = base;
    cyc(2);
    chk("run_start_cyc", 32'(last_start), 32'(c + 1));
    chk("run_start_cnt", 32'(n_start), 32'(s + 1));
    chk("run_running", 32'(running), 32'd1);
    cyc(15);
    q = n_quit;
    send(2'd2, 32'd0);
    h = base;
    cyc(1);
    stall_out();
    chk("halt_quit_cyc", 32'(last_quit), 32'(h + 1));
    chk("halt_quit_cnt", 32'(n_quit), 32'(q + 1));
    chk("halt_done_cyc", 32'(last_done), 32'(h + 3));
    chk("halt_ready", 32'(cmd_ready), 32'd1);

    // RUN while uncalibrated waits for calibration.
    init_calib_complete = 1'b0;
    s = n_start;
    send(2'd0, 32'd0);
    cyc(5);
    chk("wait_ready", 32'(cmd_ready), 32'd0);
    chk("wait_no_start", 32'(n_start), 32'(s));
    c = cyc_n;
    init_calib_complete = 1'b1;
    cyc(2);
    chk("calib_start_cyc", 32'(last_start), 32'(c + 1));
    chk("calib_start_cnt", 32'(n_start), 32'(s + 1));
    send(2'd2, 32'd0);
    cyc(1);
    stall_out();

    // STEP 3 with three retires; quit once, one cycle after the third.
    q = n_quit;
    send(2'd1, 32'd3);
    cyc(2);
    retire(32'h10);
    cyc(1);
    retire(32'h14);
    cyc(1);
    r = cyc_n;
    retire(32'h18);
    cyc(1);
    stall_out();
    chk("step3_quit_cyc", 32'(last_quit), 32'(r + 1));
    chk("step3_quit_cnt", 32'(n_quit), 32'(q + 1));

    // STEP 0 only pulses done.
    s = n_start;
    send(2'd1, 32'd0);
    c = base;
    cyc(1);
    chk("step0_done_cyc", 32'(last_done), 32'(c + 1));
    chk("step0_no_start", 32'(n_start), 32'(s));

    // Breakpoint at 0x100: 0xFC does not hit, 0x100 does.
    send(2'd3, 32'h0000_0101);
    send(2'd0, 32'd0);
    cyc(2);
    q = n_quit;
    retire(32'h0000_00FC);
    cyc(1);
    r = cyc_n;
    retire(32'h0000_0100);
    cyc(1);
    chk("brk_quit_cyc", 32'(last_quit), 32'(r + 1));
    chk("brk_quit_cnt", 32'(n_quit), 32'(q + 1));
    chk("brk_hit", 32'(break_hit), 32'd1);
    stall_out();
    send(2'd0, 32'd0);
    cyc(1);
    chk("run_clears_bh", 32'(break_hit), 32'd0);

    // HALT with stall never arriving: forced return after the timeout.
    send(2'd2, 32'd0);
    h = base;
    cyc(20);
    chk("tmo_flag", 32'(halt_tmo), 32'd1);
    chk("tmo_done_cyc", 32'(last_done), 32'(h + 17));

    // STEP 1 whose only retire also hits the breakpoint.
    q = n_quit;
    send(2'd1, 32'd1);
    cyc(2);
    retire(32'h0000_0100);
    cyc(3);
    chk("step1brk_quit_cnt", 32'(n_quit), 32'(q + 1));
    chk("step1brk_bh", 32'(break_hit), 32'd1);
    stall_out();

    // Calibration loss while running.
    send(2'd0, 32'd0);
    cyc(3);
    q = n_quit;
    c = cyc_n;
    init_calib_complete = 1'b0;
    cyc(2);
    chk("calloss_done_cyc", 32'(last_done), 32'(c + 1));
    chk("calloss_no_quit", 32'(n_quit), 32'(q));
    chk("calloss_running", 32'(running), 32'd0);
    init_calib_complete = 1'b1;
    cyc(1);

    // Reset asserted while HALTING after a breakpoint.
    send(2'd0, 32'd0);
    cyc(2);
    retire(32'h0000_0100);
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {26'd0, cpu_start, quit_cmd, running, break_hit, halt_tmo, done}, 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    q = n_quit;
    send(2'd0, 32'd0);
    cyc(2);
    retire(32'h0000_0100);
    cyc(3);
    chk("arst_brk_cleared", 32'(n_quit), 32'(q));
    chk("arst_run_again", 32'(running), 32'd1);
    send(2'd2, 32'd0);
    cyc(1);
    stall_out();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run-control initiator that drives the CPU status block's start/quit interface. It accepts decoded monitor commands (run, N-step, halt, breakpoint set/clear) and waits for DRAM calibration. It counts retired instructions, compares the retired PC against a breakpoint, and emits single-cycle cpu_start / quit_cmd pulses. It then waits for the pipeline to report stall before returning to idle. It sits between the monitor command decoder and the CPU status block.

Parameters:
STEP_W, 16, width of the step counter (max steps 2^STEP_W-1)
HALT_TMO, 15, cycles to wait for stall after quit_cmd before a forced return to idle

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
init_calib_complete  in  1  DRAM calibration done
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=RUN 1=STEP 2=HALT 3=BRK
cmd_data  in  32  STEP: count in [STEP_W-1:0]; BRK: pc[31:2], enable in bit0
stall  in  1  pipeline stall from the CPU status block
inst_retire  in  1  one instruction retired this cycle
pc_retire  in  32  PC of the retiring instruction
cpu_start  out  1  start pulse to the CPU status block
quit_cmd  out  1  quit pulse to the CPU status block
running  out  1  state is RUN or STEP
break_hit  out  1  sticky; breakpoint caused the last halt
halt_tmo  out  1  sticky; last halt timed out
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset values: cpu_start=0, quit_cmd=0, break_hit=0, halt_tmo=0, done=0, running=0, state=IDLE, brk_en=0, brk_pc=0, step_cnt=0, tmo_cnt=0.
- Reset is asynchronous and valid mid-operation. All state clears, and no quit_cmd is emitted on reset.
- States: IDLE, WAIT_CALIB, RUN, STEP, HALTING.
- cmd_ready = 1 in IDLE/RUN/STEP and 0 in WAIT_CALIB/HALTING. It is combinational from state.
- BRK is accepted in any ready state. On accept: brk_pc <= {cmd_data[31:2],2'b00}, brk_en <= cmd_data[0]. State is unchanged.
- IDLE+RUN:
  - If init_calib_complete=1: cpu_start=1 next cycle, go to RUN.
  - Otherwise go to WAIT_CALIB.
  - break_hit and halt_tmo clear on accept.
- WAIT_CALIB:
  - In the first cycle init_calib_complete=1: cpu_start=1 next cycle, go to RUN.
  - Otherwise stay.
- IDLE+STEP:
  - If count==0: no start; done pulses next cycle; stay IDLE.
  - Otherwise step_cnt <= count, and take the same calibration path as RUN (WAIT_CALIB if needed), entering STEP instead of RUN.
- IDLE+HALT: accepted; no quit_cmd; done pulses next cycle.
- RUN/STEP + RUN or STEP command: accepted and dropped, no effect.
- Halt triggers while in RUN/STEP:
  - HALT command accepted.
  - inst_retire & brk_en & pc_retire==brk_pc → break_hit <= 1.
  - STEP only: inst_retire & step_cnt==1.
- On any halt trigger: quit_cmd=1 for exactly one cycle (the next cycle), go to HALTING, tmo_cnt <= 0.
  - Simultaneous triggers produce a single quit_cmd.
  - break_hit is set if the breakpoint term is among the triggers.
- STEP decrement: step_cnt decrements by 1 on each inst_retire while in STEP. It never wraps below 0.
- Retire during stall: retires while stall=1 are still counted. The upstream block guarantees inst_retire=0 when the pipeline is stalled.
- HALTING:
  - stall=1 → go to IDLE, done=1 next cycle.
  - Otherwise tmo_cnt increments.
  - tmo_cnt==HALT_TMO → halt_tmo <= 1, go to IDLE, done=1.
- Calibration loss: init_calib_complete falls in RUN/STEP/HALTING → go directly to IDLE, no quit_cmd, done=1. The CPU status block stops itself in this case.
- Pulse discipline: cpu_start and quit_cmd are never both 1 in the same cycle. They are registered outputs.
- Latency: command accept → cpu_start is 1 cycle when calibrated. Trigger → quit_cmd is 1 cycle.

Decomposition:
- Shared package: opcode constants (OP_RUN, OP_STEP, OP_HALT, OP_BRK) and the state encoding. These are reused by the monitor command decoder.
- No sub-module is required. The breakpoint compare plus step counter may be split into run_ctrl_trig (combinational trigger + counter), but single-module is preferred.

Test Plan:
- Calibrated idle, RUN → cpu_start pulse 1 cycle after accept; running=1; HALT at cycle 20 → quit_cmd 1 cycle later; stall=1 two cycles on → done pulse, cmd_ready=1.
- init_calib_complete=0, RUN → WAIT_CALIB with cmd_ready=0; raise calib at cycle 50 → cpu_start at 51; no earlier pulse.
- STEP count=3, retires on cycles 5,7,9 → quit_cmd exactly once, at cycle 10; STEP count=0 → done pulse, no cpu_start.
- BRK pc=0x0000_0100 enable=1, RUN, retire pc 0xFC then 0x100 → quit_cmd after the 0x100 retire, break_hit=1; next RUN clears break_hit.
- STEP count=1 with first retire at pc==brk_pc → single quit_cmd, break_hit=1.
- HALT with stall held 0 → halt_tmo=1 and done after HALT_TMO=15 cycles; calibration drop during RUN → IDLE, done, no quit_cmd; rst_n asserted in HALTING → all outputs 0 immediately.
